bcm_scheduler: RTL
==================

BCM_SCHEDULER -- requirements
Module: bcm_scheduler

Interface
REQ-001 Parameter SCAN_BIT, default 3: number of row-select bits; rows = 2**SCAN_BIT.
REQ-002 Parameter BITDEPTH, default 8: bit planes per colour channel.
REQ-003 Parameter BASE_TICKS, default 16: oe_b low time in clk cycles for plane 0; legal range is 1 or more.
REQ-004 clk  in  1: clock; all logic is on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 enable  in  1: scan enable; while low, no new shifts are started.
REQ-007 shift_start  out  1: one-cycle pulse that starts the row shifter for slot (row, plane).
REQ-008 row  out  SCAN_BIT: row of the slot currently being shifted.
REQ-009 plane  out  $clog2(BITDEPTH): bit plane of the slot currently being shifted.
REQ-010 shift_done  in  1: one-cycle pulse from the shifter; the slot's columns are fully shifted.
REQ-011 latch  out  1: panel latch strobe.
REQ-012 oe_b  out  1: panel output enable, active-low.
REQ-013 select  out  SCAN_BIT: row address currently driven to the panel.
REQ-014 frame_start  out  1: one-cycle pulse coincident with shift_start of slot (row 0, plane 0).

Function
REQ-015 All outputs shall be registered.
REQ-016 Slot order: plane counts 0..BITDEPTH-1 within a row; after the last plane, row increments; row wraps from 2**SCAN_BIT-1 to 0.
REQ-017 The shift side shall have 3 states: S_IDLE, S_BUSY, S_READY.
REQ-018 S_IDLE with enable=1: pulse shift_start for one cycle and go to S_BUSY.
REQ-019 row and plane shall be held stable from shift_start until the slot is released (REQ-024).
REQ-020 S_BUSY: shift_done moves to S_READY; shift_done in any other state is ignored.
REQ-021 The display side shall have 4 states:
- M_BLANK: oe_b=1, latch=0.
- M_LATCH: latch=1, oe_b=1.
- M_POST: latch=0, oe_b=1.
- M_ON: oe_b=0.
REQ-022 M_BLANK moves to M_LATCH when the shift side is in S_READY; M_BLANK lasts at least 1 cycle.
REQ-023 M_LATCH lasts exactly 1 cycle; on entry, select is loaded with the row of the ready slot and that slot's plane is captured as the display plane.
REQ-024 Slot release happens in the M_LATCH cycle:
- the shift side returns to S_IDLE;
- the slot counter advances;
- the next shift_start may occur 1 cycle after M_LATCH at the earliest.
REQ-025 M_POST lasts exactly 1 cycle, then the FSM enters M_ON.
REQ-026 M_ON holds oe_b=0 for exactly BASE_TICKS<<display_plane cycles, then returns to M_BLANK.
REQ-027 The on-time counter shall be wide enough for BASE_TICKS<<(BITDEPTH-1) without overflow.
REQ-028 Shifting overlaps display: a shift may be in progress during M_ON.
REQ-029 If shift_done arrives before M_ON ends, the shift side waits in S_READY; no latch occurs while oe_b=0.
REQ-030 latch=1 and oe_b=0 shall never be true in the same cycle.
REQ-031 oe_b shall be high for at least one full cycle before and after every latch pulse.
REQ-032 enable deasserted mid-operation:
- a shift already in progress completes and its slot is latched and displayed;
- no new shift_start is issued;
- the FSM then rests in M_BLANK with oe_b=1.
REQ-033 enable reasserted: shift_start is issued 1 cycle later, continuing from the next slot in sequence (no reset of the slot counter).
REQ-034 shift_done in the same cycle as shift_start is ignored; the shifter must complete the slot in at least 1 cycle.

Reset
REQ-035 Output values under reset: oe_b=1, latch=0, shift_start=0, frame_start=0, row=0, plane=0, select=0.
REQ-036 Internal state under reset: shift side S_IDLE, display side M_BLANK, on-time counter 0.
REQ-037 Reset during M_ON shall drive oe_b=1 on the next clk edge.
REQ-038 After reset, the first shift_start shall be slot (0,0) with frame_start=1.

Verification
All scenarios use SCAN_BIT=1, BITDEPTH=2, BASE_TICKS=4, with the shifter model returning shift_done 10 cycles after shift_start unless stated otherwise.
REQ-039 Reset release with enable=1:
- shift_start and frame_start pulse the cycle after reset is released, with row=0, plane=0;
- latch pulses 2 cycles after shift_done at the earliest;
- oe_b is low for 4 cycles.
REQ-040 Full frame:
- slots run in order (0,0), (0,1), (1,0), (1,1), then (0,0) again;
- on-times are 4, 8, 4, 8 cycles;
- select goes 0, 0, 1, 1;
- frame_start pulses once per 4 slots.
REQ-041 Fast shifter (shift_done 2 cycles after shift_start):
- the shift side waits in S_READY until M_ON ends;
- latch never coincides with oe_b=0.
REQ-042 enable dropped during the shift of (1,0):
- (1,0) is latched and displayed for 4 cycles, then oe_b stays high;
- on re-enable, the next shift_start is slot (1,1).
REQ-043 Reset asserted in the 3rd cycle of M_ON:
- oe_b=1 the next cycle;
- after release, the next shift_start is (0,0) with frame_start=1.
REQ-044 A spurious shift_done while in S_IDLE or S_READY causes no state change and no extra latch.

Source files
------------

// File: rtl/bcm_scheduler.sv
// Binary-code-modulation scan scheduler: sequences (row, plane) slots to a row
// shifter and drives latch / output-enable so each plane is lit for BASE_TICKS<<plane cycles.
module bcm_scheduler #(
  parameter int SCAN_BIT   = 3,
  parameter int BITDEPTH   = 8,
  parameter int BASE_TICKS = 16,
  localparam int PW        = (BITDEPTH > 1) ? $clog2(BITDEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                shift_start,
  output logic [SCAN_BIT-1:0] row,
  output logic [PW-1:0]       plane,
  input  logic                shift_done,
  output logic                latch,
  output logic                oe_b,
  output logic [SCAN_BIT-1:0] select,
  output logic                frame_start
);

  localparam int ON_MAX = BASE_TICKS << (BITDEPTH - 1);
  localparam int CW     = $clog2(ON_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_READY} s_state_t;
  typedef enum logic [1:0] {M_BLANK, M_LATCH, M_POST, M_ON} m_state_t;

  s_state_t            s_reg, s_next;
  m_state_t            m_reg, m_next;
  logic [CW-1:0]       on_cnt_reg, on_cnt_next;
  logic [CW-1:0]       on_load;
  logic [PW-1:0]       disp_plane_reg, disp_plane_next;
  logic [SCAN_BIT-1:0] row_reg, row_next;
  logic [PW-1:0]       plane_reg, plane_next;
  logic [SCAN_BIT-1:0] select_reg, select_next;
  logic                shift_start_reg, shift_start_next;
  logic                frame_start_reg, frame_start_next;
  logic                latch_reg, oe_b_reg;

  always_comb begin
    s_next           = s_reg;
    m_next           = m_reg;
    on_cnt_next      = on_cnt_reg;
    disp_plane_next  = disp_plane_reg;
    row_next         = row_reg;
    plane_next       = plane_reg;
    select_next      = select_reg;
    shift_start_next = 1'b0;
    frame_start_next = 1'b0;
    on_load          = (CW'(BASE_TICKS) << disp_plane_reg) - CW'(1);

    case (s_reg)
      S_IDLE: begin
        if (enable) begin
          s_next           = S_BUSY;
          shift_start_next = 1'b1;
          frame_start_next = (row_reg == '0) && (plane_reg == '0);
        end
      end
      // A done pulse coincident with the start pulse cannot belong to this slot.
      S_BUSY: begin
        if (shift_done && !shift_start_reg) begin
          s_next = S_READY;
        end
      end
      default: s_next = s_reg;
    endcase

    case (m_reg)
      M_BLANK: begin
        if (s_reg == S_READY) begin
          m_next          = M_LATCH;
          select_next     = row_reg;
          disp_plane_next = plane_reg;
          // Release the slot: shifter may start the next one after the latch cycle.
          s_next          = S_IDLE;
          if (plane_reg == PW'(BITDEPTH - 1)) begin
            plane_next = '0;
            row_next   = row_reg + SCAN_BIT'(1);
          end else begin
            plane_next = plane_reg + PW'(1);
          end
        end
      end
      M_LATCH: m_next = M_POST;
      M_POST: begin
        m_next      = M_ON;
        on_cnt_next = on_load;
      end
      M_ON: begin
        if (on_cnt_reg == '0) begin
          m_next = M_BLANK;
        end else begin
          on_cnt_next = on_cnt_reg - CW'(1);
        end
      end
      default: m_next = M_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg           <= S_IDLE;
      m_reg           <= M_BLANK;
      on_cnt_reg      <= '0;
      disp_plane_reg  <= '0;
      row_reg         <= '0;
      plane_reg       <= '0;
      select_reg      <= '0;
      shift_start_reg <= 1'b0;
      frame_start_reg <= 1'b0;
      latch_reg       <= 1'b0;
      oe_b_reg        <= 1'b1;
    end else begin
      s_reg           <= s_next;
      m_reg           <= m_next;
      on_cnt_reg      <= on_cnt_next;
      disp_plane_reg  <= disp_plane_next;
      row_reg         <= row_next;
      plane_reg       <= plane_next;
      select_reg      <= select_next;
      shift_start_reg <= shift_start_next;
      frame_start_reg <= frame_start_next;
      // Panel strobes follow the display state being entered, so they are glitch-free.
      latch_reg       <= (m_next == M_LATCH);
      oe_b_reg        <= (m_next != M_ON);
    end
  end

  assign shift_start = shift_start_reg;
  assign frame_start = frame_start_reg;
  assign row         = row_reg;
  assign plane       = plane_reg;
  assign select      = select_reg;
  assign latch       = latch_reg;
  assign oe_b        = oe_b_reg;

endmodule
